tlp_ack_handler: RTL

// - Receive-side ACK/NACK DLLP decoder feeding packet_generator_controller (drives its i_tlp_id_ack, i_tlp_rply_start).
// - Converts cumulative sequence-ID ACK/NACK into single-cycle ack-pointer pulses.
// - Owns the replay timer, the replay-attempt limit and the sticky link-error flag.

---
 rtl/tlp_ack_handler_if.sv | 33 +++
 rtl/tlp_ack_handler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tlp_ack_handler_if.sv
// rtl/tlp_ack_handler_if.sv - DLLP input, controller pointer and handler output bundle for tlp_ack_handler.
interface tlp_ack_handler_if #(
    parameter int TLP_ID_WIDTH = 2
);
    logic                    i_dllp_valid;
    logic                    i_dllp_nack;
    logic [TLP_ID_WIDTH-1:0] i_dllp_id;
    logic                    o_dllp_ready;
    logic [TLP_ID_WIDTH-1:0] i_tlp_id_ack;
    logic [TLP_ID_WIDTH-1:0] i_tlp_id_nack;
    logic                    i_tlp_id_all_ack;
    logic                    i_tlp_id_wait_ack;
    logic                    i_tlp_rply_act;
    logic                    o_tlp_id_ack;
    logic                    o_tlp_rply_start;
    logic                    o_link_err;
    logic [15:0]             o_nack_cnt;
    logic [15:0]             o_timeout_cnt;

    modport slave (
        input  i_dllp_valid, i_dllp_nack, i_dllp_id, i_tlp_id_ack, i_tlp_id_nack,
               i_tlp_id_all_ack, i_tlp_id_wait_ack, i_tlp_rply_act,
        output o_dllp_ready, o_tlp_id_ack, o_tlp_rply_start, o_link_err,
               o_nack_cnt, o_timeout_cnt
    );

    modport master (
        output i_dllp_valid, i_dllp_nack, i_dllp_id, i_tlp_id_ack, i_tlp_id_nack,
               i_tlp_id_all_ack, i_tlp_id_wait_ack, i_tlp_rply_act,
        input  o_dllp_ready, o_tlp_id_ack, o_tlp_rply_start, o_link_err,
               o_nack_cnt, o_timeout_cnt
    );
endinterface

// File: rtl/tlp_ack_handler.sv
// rtl/tlp_ack_handler.sv - ACK/NACK DLLP decoder, replay timer and replay limit; ACK_HANDLER_STATS_EN adds NACK/timeout counters.
module tlp_ack_handler #(
    parameter int TLP_ID_WIDTH   = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RPLY_NUM   = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    tlp_ack_handler_if.slave bus
);
    localparam int W  = TLP_ID_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = $clog2(MAX_RPLY_NUM + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_RPLY, S_RPLY_WAIT} state_t;

    state_t        state, state_nxt;
    logic [W:0]    ack_left;
    logic          lat_nack;
    logic [RW-1:0] rply_cnt;
    logic [TW-1:0] timer;
    logic          link_err;
    logic [1:0]    wait_cnt;
    logic          act_seen;

    logic [W-1:0]  ptr_diff, id_diff;
    logic [W:0]    outstanding, n_ack, n_nack, n_sel;
    logic          id_ok, hs, ready, expired;
    logic          load, ack_pulse, rply_pulse, set_err;

    // Mod-2**W subtraction handles pointer wrap; the extra bit distinguishes a full window from empty.
    assign ptr_diff    = bus.i_tlp_id_nack - bus.i_tlp_id_ack;
    assign id_diff     = bus.i_dllp_id - bus.i_tlp_id_ack;
    assign outstanding = bus.i_tlp_id_wait_ack ? {1'b1, {W{1'b0}}} : {1'b0, ptr_diff};
    assign n_ack       = {1'b0, id_diff} + {{W{1'b0}}, 1'b1};
    assign n_nack      = {1'b0, id_diff};
    assign n_sel       = bus.i_dllp_nack ? n_nack : n_ack;
    assign id_ok       = bus.i_dllp_nack ? (n_nack < outstanding) : (n_ack <= outstanding);
    assign ready       = (state == S_IDLE) && !link_err;
    assign hs          = bus.i_dllp_valid && ready;
    assign expired     = (timer == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        ack_pulse  = 1'b0;
        rply_pulse = 1'b0;
        set_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (hs && id_ok) begin
                    if (n_sel != '0) begin
                        load      = 1'b1;
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt = S_RPLY;
                    end
                end else if (expired && !bus.i_tlp_id_all_ack && !link_err) begin
                    state_nxt = S_RPLY;
                end
            end
            S_ACK: begin
                ack_pulse = 1'b1;
                if (ack_left == {{W{1'b0}}, 1'b1})
                    state_nxt = lat_nack ? S_RPLY : S_IDLE;
            end
            S_RPLY: begin
                if (rply_cnt == RW'(MAX_RPLY_NUM)) begin
                    set_err   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    rply_pulse = 1'b1;
                    state_nxt  = S_RPLY_WAIT;
                end
            end
            S_RPLY_WAIT: begin
                if (act_seen && !bus.i_tlp_rply_act)
                    state_nxt = S_IDLE;
                else if (!act_seen && !bus.i_tlp_rply_act && wait_cnt == 2'd3)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            ack_left <= '0;
            lat_nack <= 1'b0;
            rply_cnt <= '0;
            timer    <= '0;
            link_err <= 1'b0;
            wait_cnt <= '0;
            act_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                ack_left <= n_sel;
                lat_nack <= bus.i_dllp_nack;
            end else if (ack_pulse) begin
                ack_left <= ack_left - {{W{1'b0}}, 1'b1};
            end
            if (load)
                rply_cnt <= '0;
            else if (rply_pulse)
                rply_cnt <= rply_cnt + {{(RW-1){1'b0}}, 1'b1};
            if (set_err)
                link_err <= 1'b1;
            if (state != S_RPLY_WAIT) begin
                wait_cnt <= '0;
                act_seen <= 1'b0;
            end else begin
                if (wait_cnt != 2'd3)
                    wait_cnt <= wait_cnt + 2'd1;
                if (bus.i_tlp_rply_act)
                    act_seen <= 1'b1;
            end
            // Expiry saturates so a DLLP arriving on the expiry cycle still wins.
            if (ack_pulse || bus.i_tlp_id_all_ack || state == S_RPLY || state == S_RPLY_WAIT)
                timer <= '0;
            else if (!expired)
                timer <= timer + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    assign bus.o_dllp_ready     = ready;
    assign bus.o_tlp_id_ack     = ack_pulse;
    assign bus.o_tlp_rply_start = rply_pulse;
    assign bus.o_link_err       = link_err;

`ifdef ACK_HANDLER_STATS_EN
    logic [15:0] nack_cnt, timeout_cnt;
    logic        nack_acc, timer_rply;

    assign nack_acc   = (state == S_IDLE) && hs && id_ok && bus.i_dllp_nack;
    assign timer_rply = (state == S_IDLE) && !(hs && id_ok) && expired
                        && !bus.i_tlp_id_all_ack && !link_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            nack_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            if (nack_acc && nack_cnt != 16'hFFFF)
                nack_cnt <= nack_cnt + 16'd1;
            if (timer_rply && timeout_cnt != 16'hFFFF)
                timeout_cnt <= timeout_cnt + 16'd1;
        end
    end

    assign bus.o_nack_cnt    = nack_cnt;
    assign bus.o_timeout_cnt = timeout_cnt;
`else
    assign bus.o_nack_cnt    = 16'h0000;
    assign bus.o_timeout_cnt = 16'h0000;
`endif
endmodule
